// File: rtl/mult_req_sched_if.sv
// Requester-side bus for mult_req_sched: per-requester Req/operands in,
// one-hot Gnt/Done plus the shared Result and Busy out.
interface mult_req_sched_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   Req;
  logic [8*N_REQ-1:0] Mcand;
  logic [8*N_REQ-1:0] Mplier;
  logic [N_REQ-1:0]   Gnt;
  logic [N_REQ-1:0]   Done;
  logic [15:0]        Result;
  logic               Busy;

  modport master (
    output Req, Mcand, Mplier,
    input  Gnt, Done, Result, Busy
  );

  modport slave (
    input  Req, Mcand, Mplier,
    output Gnt, Done, Result, Busy
  );
endinterface

// File: rtl/mult_req_sched.sv
// Shares one 8x8 signed shift-add multiplier datapath between N_REQ requesters.
// Define MULT_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module mult_req_sched #(
  parameter int N_REQ = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  mult_req_sched_if.slave        bus,
  output logic [7:0]             S_out,
  output logic                   Ld_B,
  output logic                   Clear_A,
  output logic                   Ld_A,
  output logic                   Shift_En,
  output logic                   select_op,
  input  logic                   M,
  input  logic [7:0]             Aval,
  input  logic [7:0]             Bval
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    CLEAR,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         mcand_q, mplier_q;
  logic [OW-1:0]      owner;
  logic [2:0]         k;
  logic [N_REQ-1:0]   done_q;
  logic [15:0]        result_q;
  logic               win_found;
  logic [OW-1:0]      win_idx;

`ifdef MULT_SCHED_RR_EN
  logic [OW-1:0]      rr_ptr;
  logic [OW-1:0]      cand;

  // Search upward from the pointer, wrapping, and take the first active request.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = OW'((int'(rr_ptr) + i) % N_REQ);
      if (!win_found && bus.Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`else
  always_comb begin
    win_found = |bus.Req;
    win_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.Req[i]) win_idx = OW'(i);
    end
  end
`endif

  // NOTE: every signal this block writes gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    S_out     = '0;
    Ld_B      = 1'b0;
    Clear_A   = 1'b0;
    Ld_A      = 1'b0;
    Shift_En  = 1'b0;
    select_op = 1'b0;
    case (state)
      IDLE:   if (win_found) state_nxt = LOAD_B;
      LOAD_B: begin
        S_out     = mplier_q;
        Ld_B      = 1'b1;
        state_nxt = CLEAR;
      end
      CLEAR: begin
        Clear_A   = 1'b1;
        state_nxt = ADD;
      end
      ADD: begin
        // The sign bit of a two's-complement multiplier carries weight -2^7.
        S_out     = mcand_q;
        Ld_A      = M;
        select_op = (k == 3'd7);
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Shift_En  = 1'b1;
        state_nxt = (k == 3'd7) ? DONE : ADD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      owner    <= '0;
      k        <= '0;
      done_q   <= '0;
      result_q <= '0;
`ifdef MULT_SCHED_RR_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      done_q <= '0;
      case (state)
        IDLE: if (win_found) begin
          mcand_q  <= bus.Mcand[{win_idx, 3'b000} +: 8];
          mplier_q <= bus.Mplier[{win_idx, 3'b000} +: 8];
          owner    <= win_idx;
`ifdef MULT_SCHED_RR_EN
          rr_ptr   <= OW'((int'(win_idx) + 1) % N_REQ);
`endif
        end
        CLEAR: k <= '0;
        SHIFT: if (k != 3'd7) k <= k + 3'd1;
        DONE: begin
          result_q <= {Aval, Bval};
          done_q   <= N_REQ'(1) << owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.Gnt    = (state == LOAD_B) ? (N_REQ'(1) << owner) : '0;
  assign bus.Done   = done_q;
  assign bus.Result = result_q;
  assign bus.Busy   = (state != IDLE);

endmodule

// File: tb/tb_mult_req_sched.sv
// Self-checking bench for mult_req_sched: A/B/X datapath model attached,
// directed plus $urandom stimulus against an arithmetic product model.
module tb_mult_req_sched;

  localparam int N = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  S_out;
  logic        Ld_B, Clear_A, Ld_A, Shift_En, select_op;
  logic        M;
  logic [7:0]  Aval, Bval;

  logic [7:0]  a_reg, b_reg;
  logic        x_reg;
  logic [8:0]  sum9;

  int vectors     = 0;
  int miscompares = 0;
  int tb_ptr      = 0;

  mult_req_sched_if #(.N_REQ(N)) bus ();

  mult_req_sched #(.N_REQ(N)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .S_out     (S_out),
    .Ld_B      (Ld_B),
    .Clear_A   (Clear_A),
    .Ld_A      (Ld_A),
    .Shift_En  (Shift_En),
    .select_op (select_op),
    .M         (M),
    .Aval      (Aval),
    .Bval      (Bval)
  );

  always #5 Clk = ~Clk;

  // A/B/X registers with a 9-bit add/sub unit.
  assign sum9 = {a_reg[7], a_reg} +
                (select_op ? (~{S_out[7], S_out} + 9'd1) : {S_out[7], S_out});
  assign M    = b_reg[0];
  assign Aval = a_reg;
  assign Bval = b_reg;

  always @(posedge Clk) begin
    if (Reset) begin
      a_reg <= '0;
      b_reg <= '0;
      x_reg <= 1'b0;
    end else if (Ld_B) begin
      b_reg <= S_out;
    end else if (Clear_A) begin
      a_reg <= '0;
      x_reg <= 1'b0;
    end else if (Ld_A) begin
      a_reg <= sum9[7:0];
      x_reg <= sum9[8];
    end else if (Shift_En) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Winner when every requester is active.
  function automatic int next_winner_all();
`ifdef MULT_SCHED_RR_EN
    return tb_ptr;
`else
    return 0;
`endif
  endfunction

  // Entered and left just after a negedge.
  task automatic do_op(input int idx, input logic [7:0] mc, input logic [7:0] mp,
                       input bit perturb);
    int lat, busy_lo, excl_bad;
    logic [15:0] exp;
    exp = prod(mc, mp);
    bus.Mcand[idx*8 +: 8]  = mc;
    bus.Mplier[idx*8 +: 8] = mp;
    bus.Req[idx] = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (bus.Gnt == '0 && lat < 40);
    check("gnt_lat", lat, 1);
    check("gnt_vec", bus.Gnt, onehot(idx));
    check("busy_at_gnt", bus.Busy, 1);
    bus.Req[idx] = 1'b0;
    tb_ptr = (idx + 1) % N;
    if (perturb) begin
      bus.Mcand[idx*8 +: 8]  = mc ^ 8'(($urandom() % 255) + 1);
      bus.Mplier[idx*8 +: 8] = mp ^ 8'(($urandom() % 255) + 1);
    end
    lat = 0;
    busy_lo = 0;
    excl_bad = 0;
    do begin
      @(negedge Clk);
      lat++;
      if (bus.Done == '0 && !bus.Busy) busy_lo++;
      if ($countones({Ld_B, Clear_A, Ld_A, Shift_En}) > 1) excl_bad++;
    end while (bus.Done == '0 && lat < 40);
    check("done_lat", lat, 19);
    check("done_vec", bus.Done, onehot(idx));
    check("result", bus.Result, exp);
    check("busy_gaps", busy_lo, 0);
    check("busy_at_done", bus.Busy, 0);
    check("ctl_excl", excl_bad, 0);
  endtask

  // All requesters held; three back-to-back grants.
  task automatic contend();
    logic [7:0] mc[N];
    logic [7:0] mp[N];
    int t, w;
    for (int i = 0; i < N; i++) begin
      mc[i] = 8'($urandom());
      mp[i] = 8'($urandom());
      bus.Mcand[i*8 +: 8]  = mc[i];
      bus.Mplier[i*8 +: 8] = mp[i];
    end
    bus.Req = '1;
    t = 0;
    for (int g = 0; g < 3; g++) begin
      w = next_winner_all();
      do begin
        @(negedge Clk);
        t++;
      end while (bus.Gnt == '0 && t < 60);
      check("cont_gnt", bus.Gnt, onehot(w));
      if (g > 0) check("cont_gap", t, 20);
      tb_ptr = (w + 1) % N;
      if (g == 2) bus.Req = '0;
      t = 0;
      do begin
        @(negedge Clk);
        t++;
      end while (bus.Done == '0 && t < 40);
      check("cont_done", bus.Done, onehot(w));
      check("cont_result", bus.Result, prod(mc[w], mp[w]));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, bus.Busy, 0);
    check({tag, "_gnt"}, bus.Gnt, 0);
    check({tag, "_done"}, bus.Done, 0);
    check({tag, "_result"}, bus.Result, 16'h0000);
    check({tag, "_ctl"}, {S_out, Ld_B, Clear_A, Ld_A, Shift_En, select_op}, 0);
  endtask

  initial begin
    int lat, seen;
    Reset      = 1'b1;
    bus.Req    = '0;
    bus.Mcand  = '0;
    bus.Mplier = '0;
    repeat (3) @(negedge Clk);
    check_quiet("rst");
    Reset = 1'b0;

    // Directed products.
    do_op(0, 8'h07, 8'hFD, 1'b0);
    do_op(1, 8'h80, 8'h80, 1'b0);
    do_op(0, 8'hFF, 8'h01, 1'b0);
    do_op(0, 8'h00, 8'h5A, 1'b0);
    do_op(1, 8'h7F, 8'h80, 1'b0);
    do_op(0, 8'h80, 8'h7F, 1'b0);

    // Operands changed right after Gnt must not matter.
    do_op(1, 8'h93, 8'h2C, 1'b1);

    contend();

    // Reset in the middle of sequencing aborts the operation.
    bus.Mcand[8 +: 8]  = 8'h55;
    bus.Mplier[8 +: 8] = 8'hC3;
    bus.Req[1] = 1'b1;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (bus.Gnt == '0 && lat < 40);
    check("abort_gnt", bus.Gnt, onehot(1));
    bus.Req[1] = 1'b0;
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_quiet("abort");
    Reset  = 1'b0;
    tb_ptr = 0;
    seen = 0;
    repeat (25) begin
      @(negedge Clk);
      if (bus.Done != '0) seen++;
    end
    check("abort_no_done", seen, 0);
    do_op(0, 8'h03, 8'h04, 1'b0);

    // Randomized single requests.
    for (int r = 0; r < 16; r++) begin
      do_op(int'($urandom_range(0, N - 1)), 8'($urandom()), 8'($urandom()),
            1'($urandom()));
    end

    contend();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
